exibidor_7seg_mux: RTL and testbench
====================================

EXIBIDOR_7SEG_MUX -- requirements
Module: exibidor_7seg_mux

Interface
REQ-001 The block SHALL have parameter DIV, default 50000, meaning clk cycles per digit slot (legal range 1..65535).
REQ-002 The block SHALL have parameter ACTIVE_LOW, default 1, meaning seg and an are driven active-low when 1 and active-high when 0.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, asynchronous active-low reset (0 = reset).
REQ-005 The block SHALL have port count, input, 4 bits, unsigned binary value 0..15 from the upstream counter.
REQ-006 The block SHALL have port seg, output, 7 bits, ordered {g,f,e,d,c,b,a}, segments of the currently scanned digit.
REQ-007 The block SHALL have port an, output, 2 bits, digit enables: an[0] is units, an[1] is tens.
REQ-008 The block SHALL have port dp, output, 1 bit, decimal point, driven permanently inactive.

Function
REQ-009 The prescaler SHALL count 0..DIV-1 and wrap to 0; tick SHALL be asserted in the cycle where prescaler == DIV-1; with DIV=1, tick SHALL be asserted every cycle.
REQ-010 The digit state SHALL have two states, UNI and DEZ, and SHALL toggle UNI<->DEZ on each tick edge, otherwise hold.
REQ-011 The held value SHALL load count only on a tick edge while in DEZ (frame boundary, DEZ->UNI), otherwise hold; count changes mid-frame SHALL NOT affect the display.
REQ-012 The block SHALL convert held to BCD as follows: held >= 10 gives tens=1, units=held-10; otherwise tens=0, units=held.
REQ-013 The block SHALL encode segments active-high as 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
REQ-014 In UNI, seg SHALL show units and an[0] SHALL be active, an[1] inactive.
REQ-015 In DEZ with tens=1, seg SHALL show 1 and an[1] SHALL be active, an[0] inactive.
REQ-016 In DEZ with tens=0 (leading-zero blanking), seg SHALL be all inactive and both an bits inactive.
REQ-017 seg and an SHALL be registered, reflecting digit state and held with exactly one clk of latency; a count sampled at a frame boundary SHALL appear on the pins one edge after capture.
REQ-018 When ACTIVE_LOW=1, seg and an SHALL be the bitwise inverse of the active-high values.
REQ-019 Two an bits SHALL never be active simultaneously in any cycle.

Reset
REQ-020 While rst=0, the block SHALL force prescaler=0, digit state=UNI, held=0, seg and an all inactive (0x7F/2'b11 when ACTIVE_LOW=1), and dp inactive, asynchronously.
REQ-021 Assertion of rst mid-scan SHALL take effect immediately without waiting for a clk edge.
REQ-022 At the first clk edge after rst release, the block SHALL output units digit 0 (an[0] active, seg=0x3F active-high), and the prescaler SHALL start from 0.

Structure
REQ-023 The shared package pkg_display SHALL hold the segment table constants (0..9, BLANK) and the UNI/DEZ state encoding.
REQ-024 The block SHALL instantiate one sub-module, decod_7seg: a combinational 4-bit BCD to 7-segment decoder (active-high, returning BLANK for inputs 10..15).

Verification (DIV=4, ACTIVE_LOW=1 unless stated)
REQ-025 Scenario: rst=0 for 12 ns, then release with count=0 -> seg=0x7F and an=2'b11 during reset; after the first edge, an=2'b10 and seg=0x40; tens slot blanked with an=2'b11.
REQ-026 Scenario: count=7 held -> after a frame boundary, units slot shows an=2'b10, seg=0x78; tens slot shows an=2'b11; each slot lasts 4 cycles.
REQ-027 Scenario: count=13 -> slots alternate every 4 cycles between an=2'b10 with seg=0x30 (3) and an=2'b01 with seg=0x79 (1).
REQ-028 Scenario: count changes 5->9 during a UNI slot -> 5 is displayed until the next DEZ->UNI tick, then 9 (seg=0x10) appears one edge later.
REQ-029 Scenario: count wraps 15->0 -> display shows tens 1 and units 5 (seg=0x12), then units 0 with tens blanked; an is never 2'b00.
REQ-030 Scenario: rst pulsed low mid-DEZ slot -> outputs go inactive immediately; after release, the scan restarts in UNI with a 4-cycle slot.

Source files
------------

// File: rtl/pkg_display.sv
// Shared 7-segment display definitions: segment patterns, widths and scan states.
package pkg_display;

  localparam int unsigned SEG_W   = 7;
  localparam int unsigned AN_W    = 2;
  localparam int unsigned BCD_W   = 4;
  localparam int unsigned PRESC_W = 16;

  // Segment patterns, active-high, ordered {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  typedef enum logic {
    UNI = 1'b0,
    DEZ = 1'b1
  } digit_e;

endpackage

// File: rtl/decod_7seg.sv
// Combinational BCD to 7-segment decoder, active-high; 10..15 decode to blank.
module decod_7seg
  import pkg_display::*;
(
  input  logic [BCD_W-1:0] bcd_i,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_c = SEG_0;
      4'd1:    seg_c = SEG_1;
      4'd2:    seg_c = SEG_2;
      4'd3:    seg_c = SEG_3;
      4'd4:    seg_c = SEG_4;
      4'd5:    seg_c = SEG_5;
      4'd6:    seg_c = SEG_6;
      4'd7:    seg_c = SEG_7;
      4'd8:    seg_c = SEG_8;
      4'd9:    seg_c = SEG_9;
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/exibidor_7seg_mux.sv
// Two-digit multiplexed 7-segment driver for a 0..15 count, with tens blanking
// and a frame-latched display value.
module exibidor_7seg_mux
  import pkg_display::*;
#(
  parameter int unsigned DIV        = 50000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BCD_W-1:0] count,
  output logic [SEG_W-1:0] seg,
  output logic [AN_W-1:0]  an,
  output logic             dp
);

  // XOR masks turning active-high patterns into pin polarity; also the idle levels
  localparam logic [SEG_W-1:0] SEG_OFF = {SEG_W{ACTIVE_LOW}};
  localparam logic [AN_W-1:0]  AN_OFF  = {AN_W{ACTIVE_LOW}};

  logic [PRESC_W-1:0] presc_q, presc_d;
  digit_e             digit_q, digit_d;
  logic [BCD_W-1:0]   held_q, held_d;
  logic [SEG_W-1:0]   seg_q, seg_d;
  logic [AN_W-1:0]    an_q, an_d;

  logic               tick_c;
  logic               tens_c;
  logic [BCD_W-1:0]   units_c;
  logic [BCD_W-1:0]   dec_in_c;
  logic [SEG_W-1:0]   dec_seg_c;
  logic [SEG_W-1:0]   seg_ah_c;
  logic [AN_W-1:0]    an_ah_c;

  // Binary to BCD split and selection of the digit being scanned
  always_comb begin
    tens_c   = (held_q >= BCD_W'(10));
    units_c  = tens_c ? (held_q - BCD_W'(10)) : held_q;
    dec_in_c = (digit_q == UNI) ? units_c : BCD_W'(1);
  end

  decod_7seg u_decod (
    .bcd_i (dec_in_c),
    .seg_c (dec_seg_c)
  );

  always_comb begin
    tick_c   = (presc_q == PRESC_W'(DIV - 1));
    presc_d  = tick_c ? '0 : presc_q + PRESC_W'(1);
    digit_d  = digit_q;
    held_d   = held_q;
    seg_ah_c = SEG_BLANK;
    an_ah_c  = '0;

    if (tick_c) begin
      digit_d = (digit_q == UNI) ? DEZ : UNI;
      // New value is only accepted at the frame boundary so a frame never mixes two counts
      if (digit_q == DEZ) begin
        held_d = count;
      end
    end

    if (digit_q == UNI) begin
      seg_ah_c = dec_seg_c;
      an_ah_c  = 2'b01;
    end else if (tens_c) begin
      seg_ah_c = dec_seg_c;
      an_ah_c  = 2'b10;
    end

    seg_d = seg_ah_c ^ SEG_OFF;
    an_d  = an_ah_c ^ AN_OFF;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      digit_q <= UNI;
      held_q  <= '0;
      seg_q   <= SEG_OFF;
      an_q    <= AN_OFF;
    end else begin
      presc_q <= presc_d;
      digit_q <= digit_d;
      held_q  <= held_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = ACTIVE_LOW;

endmodule

// File: tb/tb_exibidor_7seg_mux.sv
// Self-checking bench for exibidor_7seg_mux (DIV=4, active-low pins) against a
// cycle-count based reference of the scan and frame latching.
module tb_exibidor_7seg_mux;

  localparam int DIV = 4;
  localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] count = 4'd0;
  logic [6:0] seg;
  logic [1:0] an;
  logic       dp;

  int n_tests = 0;
  int n_fail  = 0;

  exibidor_7seg_mux #(.DIV(DIV), .ACTIVE_LOW(1'b1)) dut (
    .clk   (clk),
    .rst   (rst),
    .count (count),
    .seg   (seg),
    .an    (an),
    .dp    (dp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Pin image {an, seg} for a slot (0 = units, 1 = tens) showing value v, active-low
  function automatic logic [8:0] disp(input int slot, input int v);
    logic [1:0] an_ah;
    logic [6:0] seg_ah;
    an_ah  = 2'b00;
    seg_ah = 7'h00;
    if (slot == 0) begin
      an_ah  = 2'b01;
      seg_ah = SEG_TAB[v % 10];
    end else if (v >= 10) begin
      an_ah  = 2'b10;
      seg_ah = SEG_TAB[v / 10];
    end
    return ~{an_ah, seg_ah};
  endfunction

  // Reference: edges since reset release fix the slot; value latched at end of each tens slot
  int         edges  = 0;
  int         held_m = 0;
  logic [8:0] exp_disp = 9'h1FF;

  always @(posedge clk or negedge rst) begin
    int slot;
    if (!rst) begin
      edges    = 0;
      held_m   = 0;
      exp_disp = 9'h1FF;
    end else begin
      slot     = (edges / DIV) % 2;
      exp_disp = disp(slot, held_m);
      if ((edges % DIV) == DIV - 1 && slot == 1) held_m = int'(count);
      edges++;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("seg_rst", 32'(seg), 32'h7F);
      chk("an_rst", 32'(an), 32'h3);
    end else begin
      chk("seg", 32'(seg), 32'(exp_disp[6:0]));
      chk("an", 32'(an), 32'(exp_disp[8:7]));
    end
    chk("an_excl", 32'(an != 2'b00), 32'h1);
    chk("dp", 32'(dp), 32'h1);
  end

  // Asynchronous reset pulse at a non-edge time, with an immediate output check
  task automatic reset_pulse();
    @(negedge clk);
    #3 rst = 1'b0;
    #1;
    chk("seg_async_rst", 32'(seg), 32'h7F);
    chk("an_async_rst", 32'(an), 32'h3);
    #10 rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    #10;
    chk("seg_in_rst", 32'(seg), 32'h7F);
    chk("an_in_rst", 32'(an), 32'h3);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("first_an", 32'(an), 32'h2);
    chk("first_seg", 32'(seg), 32'h40);
    repeat (12) @(negedge clk);

    count = 4'd7;
    repeat (20) @(negedge clk);
    count = 4'd13;
    repeat (20) @(negedge clk);
    count = 4'd5;
    repeat (16) @(negedge clk);
    repeat (2) @(negedge clk);
    count = 4'd9;
    repeat (16) @(negedge clk);
    count = 4'd15;
    repeat (16) @(negedge clk);
    count = 4'd0;
    repeat (16) @(negedge clk);

    // Mid-tens-slot reset: latch 13, wait until the tens digit is lit, then reset
    count = 4'd13;
    reset_pulse();
    repeat (13) @(negedge clk);
    chk("dez_before_rst", 32'(an), 32'h1);
    reset_pulse();
    repeat (10) @(negedge clk);

    repeat (60) begin
      count = 4'($urandom_range(0, 15));
      repeat ($urandom_range(1, 20)) @(negedge clk);
      if ($urandom_range(0, 15) == 0) reset_pulse();
    end
    repeat (8) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
